// File: rtl/serializer_tx.sv
// Serializes 32-bit words as "11" header + MSB-first payload + idle-low gap; first header bit one cycle after load.
// One-word holding buffer; data_ready = !hold_full (registered), so a full buffer stalls the source.
module serializer_tx #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [1:0] HEADER     = 2'b11,
    parameter int         GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  data_out,
    output logic                  tx_active,
    output logic                  frame_done
);

    localparam int CNT_MAX = (DATA_WIDTH > GAP_CYCLES) ? DATA_WIDTH : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("serializer_tx: GAP_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] shift, shift_nxt;
    logic [DATA_WIDTH-1:0] hold;
    logic                  hold_full, hold_full_nxt;
    logic                  data_out_nxt, tx_active_nxt, frame_done_nxt;
    logic                  load, accept;

    assign data_ready = !hold_full;
    assign accept     = data_valid && !hold_full;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        shift_nxt      = shift;
        data_out_nxt   = 1'b0;
        tx_active_nxt  = 1'b0;
        frame_done_nxt = 1'b0;
        load           = 1'b0;

        case (state)
            ST_IDLE: begin
                if (hold_full) begin
                    load = 1'b1;
                end
            end
            ST_HEADER: begin
                tx_active_nxt = 1'b1;
                if (cnt == '0) begin
                    cnt_nxt      = CNT_W'(1);
                    data_out_nxt = HEADER[0];
                end else begin
                    state_nxt    = ST_DATA;
                    cnt_nxt      = '0;
                    data_out_nxt = shift[DATA_WIDTH-1];
                    shift_nxt    = shift << 1;
                end
            end
            ST_DATA: begin
                if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                    state_nxt      = ST_GAP;
                    cnt_nxt        = '0;
                    frame_done_nxt = 1'b1;
                end else begin
                    tx_active_nxt = 1'b1;
                    cnt_nxt       = cnt + 1'b1;
                    data_out_nxt  = shift[DATA_WIDTH-1];
                    shift_nxt     = shift << 1;
                end
            end
            ST_GAP: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    if (hold_full) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Starting a frame drives the first header bit in the same edge as the load.
        if (load) begin
            state_nxt     = ST_HEADER;
            cnt_nxt       = '0;
            shift_nxt     = hold;
            data_out_nxt  = HEADER[1];
            tx_active_nxt = 1'b1;
        end

        hold_full_nxt = hold_full;
        if (load) begin
            hold_full_nxt = 1'b0;
        end else if (accept) begin
            hold_full_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            shift      <= '0;
            hold_full  <= 1'b0;
            data_out   <= 1'b0;
            tx_active  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shift      <= shift_nxt;
            hold_full  <= hold_full_nxt;
            data_out   <= data_out_nxt;
            tx_active  <= tx_active_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    // Payload register needs no reset; it is only read once hold_full is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold <= data_in;
        end
    end

endmodule

// File: tb/tb_serializer_tx.sv
// Bench for serializer_tx: fixed-frame vector table, hand sequences, randomized traffic vs. a frame-timing model.
module tb_serializer_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        data_valid;
    logic        data_ready, data_out, tx_active, frame_done;
    logic        data_ready_g1, data_out_g1, tx_active_g1, frame_done_g1;

    int vec = 0;
    int mis = 0;

    always #5 clk = ~clk;

    serializer_tx #(.DATA_WIDTH(32), .HEADER(2'b11), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .data_out(data_out), .tx_active(tx_active), .frame_done(frame_done)
    );

    serializer_tx #(.DATA_WIDTH(32), .HEADER(2'b11), .GAP_CYCLES(1)) dut_g1 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready_g1), .data_out(data_out_g1), .tx_active(tx_active_g1),
        .frame_done(frame_done_g1)
    );

    typedef struct {
        logic [31:0] word;
        logic [33:0] stream;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        step();
        step();
        chk("rst_data_out", {31'b0, data_out}, 32'd0);
        chk("rst_tx_active", {31'b0, tx_active}, 32'd0);
        chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
        chk("rst_data_ready", {31'b0, data_ready}, 32'd1);
        rst = 1'b0;
        step();
    endtask

    // Line bit at offset `off` from a frame's first header bit (0 outside the frame).
    function automatic logic frame_bit(input int off, input logic [31:0] w);
        if (off == 0 || off == 1) return 1'b1;
        if (off >= 2 && off <= 33) return w[33-off];
        return 1'b0;
    endfunction

    int          f_start[$];
    logic [31:0] f_word[$];

    initial begin
        tbl[0] = '{word: 32'hDEADBEEF, stream: 34'h3DEADBEEF};
        tbl[1] = '{word: 32'h00000000, stream: 34'h300000000};
        tbl[2] = '{word: 32'hFFFFFFFF, stream: 34'h3FFFFFFFF};
        tbl[3] = '{word: 32'h80000001, stream: 34'h380000001};

        // Single frames from idle: accept at E0, line E1..E34, frame_done at E35.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            data_in    = tbl[i].word;
            data_valid = 1'b1;
            step();
            data_valid = 1'b0;
            data_in    = $urandom;
            chk("e0_ready", {31'b0, data_ready}, 32'd0);
            chk("e0_line", {31'b0, data_out}, 32'd0);
            for (int e = 1; e <= 37; e++) begin
                step();
                chk($sformatf("single%0d_line_e%0d", i, e), {31'b0, data_out},
                    {31'b0, (e <= 34) ? tbl[i].stream[34-e] : 1'b0});
                chk($sformatf("single%0d_txa_e%0d", i, e), {31'b0, tx_active}, {31'b0, e <= 34});
                chk($sformatf("single%0d_done_e%0d", i, e), {31'b0, frame_done}, {31'b0, e == 35});
                if (e == 1) chk("single_ready_e1", {31'b0, data_ready}, 32'd1);
            end
        end

        // Back-to-back with valid held: second word accepted at E2; GAP=2 -> 36 spacing, GAP=1 -> 35.
        do_reset();
        data_in    = 32'hA5A5A5A5;
        data_valid = 1'b1;
        step();
        data_in = 32'h0000FFFF;
        for (int e = 1; e <= 75; e++) begin
            step();
            if (e == 1) begin
                chk("b2b_ready_e1", {31'b0, data_ready}, 32'd1);
                chk("b2b_g1_ready_e1", {31'b0, data_ready_g1}, 32'd1);
            end
            if (e == 2) begin
                chk("b2b_ready_e2", {31'b0, data_ready}, 32'd0);
                data_valid = 1'b0;
            end
            chk($sformatf("b2b_line_e%0d", e), {31'b0, data_out},
                {31'b0, frame_bit(e - 1, 32'hA5A5A5A5) | frame_bit(e - 37, 32'h0000FFFF)});
            chk($sformatf("b2b_done_e%0d", e), {31'b0, frame_done}, {31'b0, e == 35 || e == 71});
            chk($sformatf("b2b_g1_line_e%0d", e), {31'b0, data_out_g1},
                {31'b0, frame_bit(e - 1, 32'hA5A5A5A5) | frame_bit(e - 36, 32'h0000FFFF)});
            chk($sformatf("b2b_g1_done_e%0d", e), {31'b0, frame_done_g1}, {31'b0, e == 35 || e == 70});
        end

        // Reset during data bit 10 (edge E13) with a second word held.
        do_reset();
        data_in    = 32'hFFFFFFFF;
        data_valid = 1'b1;
        step();
        data_in = 32'h12345678;
        for (int e = 1; e <= 13; e++) begin
            step();
            if (e == 2) data_valid = 1'b0;
        end
        chk("abort_pre_line", {31'b0, data_out}, 32'd1);
        chk("abort_pre_ready", {31'b0, data_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_async_line", {31'b0, data_out}, 32'd0);
        chk("abort_async_txa", {31'b0, tx_active}, 32'd0);
        step();
        rst = 1'b0;
        for (int e = 0; e < 60; e++) begin
            step();
            chk("abort_idle_line", {31'b0, data_out}, 32'd0);
            chk("abort_idle_done", {31'b0, frame_done}, 32'd0);
            chk("abort_idle_ready", {31'b0, data_ready}, 32'd1);
        end

        // Randomized traffic vs. frame-timing model (GAP=2, 36-cycle frame period).
        do_reset();
        begin
            int  last_start = -1000;
            int  pend_until = -100;
            bit  model_rdy  = 1'b1;
            bit  acc;
            bit  e_line, e_txa, e_done;
            int  s, off;
            for (int t = 0; t < 3100; t++) begin
                acc = data_valid && model_rdy;
                step();
                if (acc) begin
                    s = (t + 1 > last_start + 36) ? t + 1 : last_start + 36;
                    f_start.push_back(s);
                    f_word.push_back(data_in);
                    last_start = s;
                    pend_until = s;
                end
                model_rdy = (t >= pend_until);
                e_line = 1'b0;
                e_txa  = 1'b0;
                e_done = 1'b0;
                foreach (f_start[k]) begin
                    off = t - f_start[k];
                    if (off >= 0 && off <= 33) begin
                        e_txa  = 1'b1;
                        e_line = frame_bit(off, f_word[k]);
                    end
                    if (off == 34) e_done = 1'b1;
                end
                chk("rnd_line", {31'b0, data_out}, {31'b0, e_line});
                chk("rnd_txa", {31'b0, tx_active}, {31'b0, e_txa});
                chk("rnd_done", {31'b0, frame_done}, {31'b0, e_done});
                chk("rnd_ready", {31'b0, data_ready}, {31'b0, model_rdy});
                if (acc) data_valid = 1'b0;
                if (!data_valid && t < 2950) begin
                    if ($urandom_range(0, 99) < ((((t / 250) % 2) == 1) ? 5 : 80)) begin
                        data_valid = 1'b1;
                        data_in    = $urandom;
                    end
                end
            end
            chk("rnd_frames_sent", f_start.size(), (f_start.size() > 40) ? f_start.size() : 41);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
